// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//
// Writer side of the CPU instruction-memory interface. A host streams bytes over
// a valid/ready handshake. A frame is laid out as follows:
//     SYNC_BYTE, N, {hi, lo} x N [, checksum]
// The N 16-bit words are written to instruction memory at addresses 0..N-1.
// The CPU is kept disabled until a complete, legal image has been loaded.
//
// Optional feature (macro PROGRAM_LOADER_CHECKSUM_EN):
//     When this macro is defined, one checksum byte follows the last word (or
//     follows N when N==0). The checksum is the XOR of N and every data byte.
//     A match ends in DONE and a mismatch ends in ERR. Words already written
//     stay in memory.
//
// Parameters:
//     ADDR_W     instruction memory address width (capacity 2**ADDR_W words)
//     SYNC_BYTE  frame start marker
//
// Ports:
//     clk         system clock, rising edge
//     reset       asynchronous active-low reset
//     in_valid    host byte valid
//     in_data     host byte
//     in_ready    loader accepts a byte (transfer = in_valid && in_ready)
//     load_req    one-cycle pulse, restarts loading from DONE or ERR
//     imem_we     instruction memory write strobe (one cycle per word)
//     imem_addr   write address (held while imem_we is low)
//     imem_wdata  write data (held while imem_we is low)
//     cpu_enable  CPU enable, high only in DONE
//     done        image loaded successfully
//     error       frame rejected
//     word_count  words written in the current frame
// -----------------------------------------------------------------------------
module program_loader #(
    parameter int         ADDR_W    = 6,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              load_req,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              cpu_enable,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    // The comparison width is wide enough to hold both the 8-bit length and
    // 2**ADDR_W. This lets N==2**ADDR_W be accepted and N>2**ADDR_W be rejected.
    localparam int                   CMP_W    = (ADDR_W + 2 > 9) ? ADDR_W + 2 : 9;
    localparam logic [CMP_W-1:0]     CAPACITY = CMP_W'(1) << ADDR_W;
    localparam logic [CMP_W-1:0]     CMP_ONE  = CMP_W'(1);
    localparam logic [ADDR_W:0]      WC_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_HI   = 3'd2,
        S_LO   = 3'd3,
        S_CSUM = 3'd4,
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } state_t;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam state_t END_STATE = S_CSUM;
`else
    localparam state_t END_STATE = S_DONE;
`endif

    state_t              state_r;
    state_t              state_next_s;
    logic                take_s;
    logic                last_word_s;
    logic                len_zero_s;
    logic                len_too_big_s;
    logic                csum_match_s;

    logic                in_ready_r;
    logic                imem_we_r;
    logic [ADDR_W-1:0]   imem_addr_r;
    logic [15:0]         imem_wdata_r;
    logic                cpu_enable_r;
    logic                done_r;
    logic                error_r;
    logic [ADDR_W:0]     word_count_r;
    logic [7:0]          n_r;
    logic [7:0]          hi_r;

    // Returns whether a state accepts host bytes.
    function automatic logic accepts_input(input state_t s);
        logic acc;
        case (s)
            S_IDLE, S_LEN, S_HI, S_LO, S_CSUM: acc = 1'b1;
            default:                           acc = 1'b0;
        endcase
        return acc;
    endfunction

    // Decodes the handshake and the length and word-count conditions.
    always_comb begin
        take_s        = in_valid && in_ready_r;
        len_zero_s    = (in_data == 8'h00);
        len_too_big_s = (CMP_W'(in_data) > CAPACITY);
        // The word being written now is word N when the count before the
        // increment equals N-1.
        last_word_s   = ((CMP_W'(word_count_r) + CMP_ONE) == CMP_W'(n_r));
    end

    // Computes the next state of the frame parser.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (take_s && (in_data == SYNC_BYTE)) begin
                    state_next_s = S_LEN;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_LEN: begin
                if (!take_s) begin
                    state_next_s = S_LEN;
                end else if (len_zero_s) begin
                    state_next_s = END_STATE;
                end else if (len_too_big_s) begin
                    state_next_s = S_ERR;
                end else begin
                    state_next_s = S_HI;
                end
            end
            S_HI: begin
                if (take_s) begin
                    state_next_s = S_LO;
                end else begin
                    state_next_s = S_HI;
                end
            end
            S_LO: begin
                if (!take_s) begin
                    state_next_s = S_LO;
                end else if (last_word_s) begin
                    state_next_s = END_STATE;
                end else begin
                    state_next_s = S_HI;
                end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (!take_s) begin
                    state_next_s = S_CSUM;
                end else if (csum_match_s) begin
                    state_next_s = S_DONE;
                end else begin
                    state_next_s = S_ERR;
                end
            end
`endif
            S_DONE, S_ERR: begin
                if (load_req) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = state_r;
                end
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // Holds the state register and derives the status outputs from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= S_IDLE;
            in_ready_r   <= 1'b0;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
            cpu_enable_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            in_ready_r   <= accepts_input(state_next_s);
            done_r       <= (state_next_s == S_DONE);
            error_r      <= (state_next_s == S_ERR);
            cpu_enable_r <= (state_next_s == S_DONE);
        end
    end

    // Holds the frame datapath: length latch, upper byte, memory write port, and word counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            imem_we_r    <= 1'b0;
            imem_addr_r  <= '0;
            imem_wdata_r <= 16'h0000;
            word_count_r <= '0;
            n_r          <= 8'h00;
            hi_r         <= 8'h00;
        end else begin
            imem_we_r <= 1'b0;
            if (take_s) begin
                case (state_r)
                    S_LEN: begin
                        n_r          <= in_data;
                        word_count_r <= '0;
                    end
                    S_HI: begin
                        hi_r <= in_data;
                    end
                    S_LO: begin
                        imem_we_r    <= 1'b1;
                        imem_wdata_r <= {hi_r, in_data};
                        imem_addr_r  <= word_count_r[ADDR_W-1:0];
                        word_count_r <= word_count_r + WC_ONE;
                    end
                    default: begin
                    end
                endcase
            end
            if (((state_r == S_DONE) || (state_r == S_ERR)) && load_req) begin
                word_count_r <= '0;
            end
        end
    end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0] csum_r;

    // Compares the received checksum byte with the running XOR.
    always_comb begin
        csum_match_s = (in_data == csum_r);
    end

    // Accumulates the XOR of N and every data byte. The value is seeded when LEN is entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csum_r <= 8'h00;
        end else if (take_s) begin
            case (state_r)
                S_IDLE:      csum_r <= 8'h00;
                S_LEN:       csum_r <= in_data;
                S_HI, S_LO:  csum_r <= csum_r ^ in_data;
                default:     csum_r <= csum_r;
            endcase
        end
    end
`else
    // There is no checksum stage in this build.
    always_comb begin
        csum_match_s = 1'b0;
    end
`endif

    assign in_ready   = in_ready_r;
    assign imem_we    = imem_we_r;
    assign imem_addr  = imem_addr_r;
    assign imem_wdata = imem_wdata_r;
    assign cpu_enable = cpu_enable_r;
    assign done       = done_r;
    assign error      = error_r;
    assign word_count = word_count_r;

endmodule

// File: tb/tb_program_loader.sv
// -----------------------------------------------------------------------------
// tb_program_loader
//
// Self-checking bench for program_loader (ADDR_W=6). Byte frames are streamed
// through the handshake. A frame-level reference model computes the expected
// memory writes, the write timing, and the final status. The frame-level
// model is built from the frame format and does not follow the RTL state
// machine. The bench follows PROGRAM_LOADER_CHECKSUM_EN in the same way as
// the design.
// -----------------------------------------------------------------------------
module tb_program_loader;

    localparam int         AW      = 6;
    localparam logic [7:0] SYNC    = 8'hA5;
    localparam int         CAP     = 64;
    localparam int         ST_NONE = 0;
    localparam int         ST_DONE = 1;
    localparam int         ST_ERR  = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready;
    logic          load_req = 1'b0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [15:0]   imem_wdata;
    logic          cpu_enable;
    logic          done;
    logic          error;
    logic [AW:0]   word_count;

    program_loader #(.ADDR_W(AW), .SYNC_BYTE(SYNC)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .load_req   (load_req),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_enable (cpu_enable),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;

    wr_t        obs_q[$];
    wr_t        exp_q[$];
    int         lat_q[$];
    int         lo_idx_q[$];
    logic [7:0] frame_q[$];
    logic [15:0] mem [0:CAP-1];
    int         we_run_violations = 0;
    logic       we_prev = 1'b0;
    int         exp_state;
    int         exp_wc;

    // This monitor records every memory write and keeps a shadow copy of the memory.
    always @(negedge clk) begin
        if (imem_we) begin
            obs_q.push_back('{int'(imem_addr), int'(imem_wdata), cyc});
            mem[imem_addr] = imem_wdata;
        end
        if (imem_we && we_prev) we_run_violations++;
        we_prev = imem_we;
    end

    // This is the frame-level reference. It finds the sync byte, reads N, pairs the data bytes into words, and handles the checksum byte.
    task automatic model_frame();
        int   i;
        int   n;
        logic [7:0] acc;
        exp_q.delete();
        lo_idx_q.delete();
        i = 0;
        while (i < frame_q.size() && frame_q[i] != SYNC) i++;
        if (i + 1 >= frame_q.size()) begin
            exp_state = ST_NONE;
            exp_wc    = 0;
            return;
        end
        n   = int'(frame_q[i+1]);
        acc = frame_q[i+1];
        if (n > CAP) begin
            exp_state = ST_ERR;
            exp_wc    = 0;
            return;
        end
        for (int k = 0; k < n; k++) begin
            exp_q.push_back('{k, int'({frame_q[i+2+2*k], frame_q[i+3+2*k]}), 0});
            lo_idx_q.push_back(i + 3 + 2*k);
            acc = acc ^ frame_q[i+2+2*k] ^ frame_q[i+3+2*k];
        end
        exp_wc = n;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        exp_state = (frame_q[i+2+2*n] == acc) ? ST_DONE : ST_ERR;
`else
        exp_state = ST_DONE;
`endif
    endtask

    // This task presents one byte after an idle gap and waits, within a bound, for the transfer.
    task automatic send_byte(input logic [7:0] b, input int gap, output int xc);
        xc = -1;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        for (int w = 0; w < 100; w++) begin
            if (in_ready) begin
                @(posedge clk);
                #1;
                xc = cyc;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        if (xc < 0) check_value("xfer_timeout", {31'd0, in_ready}, 32'd1);
    endtask

    // This task sends the first nbytes of frame_q (all of it when nbytes < 0). It stalls 5 cycles before index stall_idx and records the transfer cycle of each LO byte.
    task automatic run_frame(input int max_gap, input int stall_idx, input int nbytes);
        int xc;
        int j;
        int lim;
        j   = 0;
        lim = (nbytes < 0) ? frame_q.size() : nbytes;
        lat_q.delete();
        for (int i = 0; i < lim; i++) begin
            send_byte(frame_q[i], (i == stall_idx) ? 5 : int'($urandom_range(0, max_gap)), xc);
            if (j < lo_idx_q.size() && lo_idx_q[j] == i) begin
                lat_q.push_back(xc);
                j++;
            end
        end
        in_valid = 1'b0;
    endtask

    // This task compares the observed writes and the final status with the model.
    task automatic finish_frame(input string tag);
        repeat (2) @(negedge clk);
        check_value({tag, "_nwr"}, obs_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k < obs_q.size()) begin
                check_value($sformatf("%s_addr%0d", tag, k), obs_q[k].addr, exp_q[k].addr);
                check_value($sformatf("%s_data%0d", tag, k), obs_q[k].data, exp_q[k].data);
                if (k < lat_q.size())
                    check_value($sformatf("%s_lat%0d", tag, k), obs_q[k].cyc, lat_q[k]);
            end
        end
        check_value({tag, "_done"}, {31'd0, done},       {31'd0, exp_state == ST_DONE});
        check_value({tag, "_err"},  {31'd0, error},      {31'd0, exp_state == ST_ERR});
        check_value({tag, "_cpu"},  {31'd0, cpu_enable}, {31'd0, exp_state == ST_DONE});
        check_value({tag, "_rdy"},  {31'd0, in_ready},   {31'd0, exp_state == ST_NONE});
        check_value({tag, "_wc"},   32'(word_count),     exp_wc);
        obs_q.delete();
    endtask

    // This task pulses load_req and checks that the loader is back in IDLE with its status cleared.
    task automatic restart(input string tag);
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        check_value({tag, "_rs_done"}, {31'd0, done},       32'd0);
        check_value({tag, "_rs_err"},  {31'd0, error},      32'd0);
        check_value({tag, "_rs_cpu"},  {31'd0, cpu_enable}, 32'd0);
        check_value({tag, "_rs_wc"},   32'(word_count),     32'd0);
        check_value({tag, "_rs_rdy"},  {31'd0, in_ready},   32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check_value({tag, "_rdy"},   {31'd0, in_ready},   32'd0);
        check_value({tag, "_we"},    {31'd0, imem_we},    32'd0);
        check_value({tag, "_addr"},  32'(imem_addr),      32'd0);
        check_value({tag, "_wdata"}, 32'(imem_wdata),     32'd0);
        check_value({tag, "_cpu"},   {31'd0, cpu_enable}, 32'd0);
        check_value({tag, "_done"},  {31'd0, done},       32'd0);
        check_value({tag, "_err"},   {31'd0, error},      32'd0);
        check_value({tag, "_wc"},    32'(word_count),     32'd0);
    endtask

    // This task appends the checksum byte that the model would accept. When bad is 1, the byte is corrupted.
    task automatic push_checksum(input logic bad);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        int   s;
        logic [7:0] acc;
        s   = 0;
        while (frame_q[s] != SYNC) s++;
        acc = 8'h00;
        for (int i = s + 1; i < frame_q.size(); i++) acc = acc ^ frame_q[i];
        frame_q.push_back(bad ? (acc ^ 8'h5A) : acc);
`else
        if (bad) frame_q.push_back(8'h00);
        else frame_q.delete(frame_q.size());
`endif
    endtask

    task automatic build_random(input int junk, input int n, input logic bad);
        logic [7:0] b;
        frame_q.delete();
        for (int i = 0; i < junk; i++) begin
            b = 8'($urandom_range(0, 255));
            if (b == SYNC) b = b ^ 8'h01;
            frame_q.push_back(b);
        end
        frame_q.push_back(SYNC);
        frame_q.push_back(8'(n));
        if (n <= CAP) begin
            for (int i = 0; i < 2*n; i++) frame_q.push_back(8'($urandom_range(0, 255)));
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            push_checksum(bad);
`endif
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int r;
        // Reset values
        #12;
        check_reset_values("reset");
        @(negedge clk);
        reset = 1'b1;

        // A junk byte is dropped, then a two-word frame is loaded.
        frame_q = '{8'h3C, 8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        push_checksum(1'b0);
`endif
        model_frame();
        run_frame(0, -1, -1);
        finish_frame("two_words");
        check_value("we_width", we_run_violations, 0);
        restart("two_words");

        // An empty image completes without any write.
        frame_q = '{8'hA5, 8'h00};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        frame_q.push_back(8'h00);
`endif
        model_frame();
        run_frame(0, -1, -1);
        finish_frame("empty");
        restart("empty");

        // A length one word over capacity is rejected.
        frame_q = '{8'hA5, 8'h41};
        model_frame();
        run_frame(0, -1, -1);
        finish_frame("oversize");
        restart("oversize");

        // A 5-cycle stall between the HI and LO bytes of word 0.
        frame_q = '{8'hA5, 8'h01, 8'hBE, 8'hEF};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        push_checksum(1'b0);
`endif
        model_frame();
        run_frame(0, 3, -1);
        finish_frame("stall");
        restart("stall");

        // Reset after one of three words, then reload.
        frame_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        push_checksum(1'b0);
`endif
        model_frame();
        run_frame(0, -1, 4);
        repeat (2) @(negedge clk);
        check_value("partial_nwr", obs_q.size(), 1);
        if (obs_q.size() > 0) check_value("partial_data", obs_q[0].data, 32'h1122);
        reset = 1'b0;
        #1;
        check_reset_values("midreset");
        obs_q.delete();
        @(negedge clk);
        reset = 1'b1;
        run_frame(1, -1, -1);
        finish_frame("reload");
        restart("reload");

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        // Good and bad checksum on the same one-word frame.
        frame_q = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h27};
        model_frame();
        run_frame(0, -1, -1);
        finish_frame("csum_ok");
        restart("csum_ok");
        frame_q = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h00};
        model_frame();
        run_frame(0, -1, -1);
        finish_frame("csum_bad");
        check_value("csum_bad_mem0", 32'(mem[0]), 32'h1234);
        restart("csum_bad");
`endif

        // Randomized frames: small, full-capacity, and oversize lengths.
        for (int t = 0; t < 25; t++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      n = $urandom_range(CAP + 1, 255);
            else if (r == 1) n = CAP;
            else             n = $urandom_range(0, 6);
            build_random($urandom_range(0, 2), n, 1'($urandom_range(0, 3) == 0));
            model_frame();
            run_frame(2, -1, -1);
            finish_frame($sformatf("rnd%0d", t));
            restart($sformatf("rnd%0d", t));
        end
        check_value("we_width_final", we_run_violations, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
